systemx_sweeper: RTL and testbench

- Sequential stimulus/capture stage wrapped around the combinational `systemx` block.
- Drives `systemx` inputs A, B, C through all 8 combinations, 000 to 111, holding each for DWELL clocks.
- Samples F at the end of each hold and assembles an 8-bit truth vector.
- Compares that vector against a parameterised expected table, so `systemx` can be self-checked in hardware without a testbench-driven sweep.

---
 rtl/systemx_sweeper.sv | 82 ++++++++
 tb/tb_systemx_sweeper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/systemx_sweeper.sv
// systemx_sweeper: steps {A,B,C} through 000..111, holding each for DWELL clocks, captures F into an 8-bit truth vector and compares it with EXPECTED.
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          sweep request, honoured only in IDLE or DONE
//   f_in           F from systemx, combinational from a/b/c_out
//   a_out/b_out/c_out  registered sweep index, a_out is the MSB
//   busy           high while sweeping
//   done           high from sweep completion until the next accepted start
//   truth          captured F values, bit i = F at index i
//   match          truth == EXPECTED while done, 0 otherwise
module systemx_sweeper #(
    parameter int unsigned DWELL    = 10,
    parameter logic [7:0]  EXPECTED = 8'h45
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic       match
);
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
    localparam logic [7:0] LAST = 8'(DWELL - 1);
    state_t     r_state, w_state;
    logic [2:0] r_index, w_index;
    logic [7:0] r_dwell, w_dwell;
    logic [7:0] r_truth, w_truth;
    logic       w_last;
    assign w_last = r_dwell == LAST;
    always_comb begin
        w_state = r_state;
        w_index = r_index;
        w_dwell = r_dwell;
        w_truth = r_truth;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_state = DRIVE;
                w_index = 3'd0;
                w_dwell = 8'd0;
                w_truth = 8'd0;
            end
            DRIVE: if (w_last) begin
                // f_in still reflects the current index during the last hold cycle
                w_truth[r_index] = f_in;
                w_dwell          = 8'd0;
                w_index          = r_index + 3'd1;
                w_state          = (r_index == 3'd7) ? DONE : DRIVE;
            end else begin
                w_dwell = r_dwell + 8'd1;
            end
            default: begin
                w_state = IDLE;
                w_index = 3'd0;
                w_dwell = 8'd0;
                w_truth = 8'd0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_index <= 3'd0;
            r_dwell <= 8'd0;
            r_truth <= 8'd0;
        end else begin
            r_state <= w_state;
            r_index <= w_index;
            r_dwell <= w_dwell;
            r_truth <= w_truth;
        end
    end
    assign {a_out, b_out, c_out} = r_index;
    assign busy  = r_state == DRIVE;
    assign done  = r_state == DONE;
    assign truth = r_truth;
    assign match = (r_state == DONE) ? (r_truth == EXPECTED) : 1'b0;
endmodule

// File: tb/tb_systemx_sweeper.sv
// tb_systemx_sweeper: randomized scoreboard bench for systemx_sweeper against a timing-arithmetic reference model.
module tb_systemx_sweeper;
    localparam int         DW  = 3;
    localparam logic [7:0] EXP = 8'h45;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       f_in;
    logic       a_out, b_out, c_out, busy, done, match;
    logic [7:0] truth;
    logic [7:0] tbl = 8'h00;

    typedef struct {
        logic [7:0] truth;
        logic       match;
        int         end_edge;
    } exp_t;
    exp_t q[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ecount = 0;
    int         mode = 0;
    int         m_k = 0;
    logic [7:0] m_tt = 8'h00;
    logic       prev_done = 1'b0;
    int         mt;
    logic [7:0] mk;

    systemx_sweeper #(.DWELL(DW), .EXPECTED(EXP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .f_in  (f_in),
        .a_out (a_out),
        .b_out (b_out),
        .c_out (c_out),
        .busy  (busy),
        .done  (done),
        .truth (truth),
        .match (match)
    );

    assign f_in = tbl[{a_out, b_out, c_out}];

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, ecount);
        end
    endtask

    // Model: mode 0 idle, 1 sweeping since edge m_k, 2 done holding m_tt.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending sweep");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_truth", truth, e.truth);
                    chk("done_match", match, e.match);
                    chk("done_edge", ecount, e.end_edge);
                end
            end
            if (mode == 1) begin
                mt = ecount - m_k;
                if (mt >= 8 * DW) mode = 2;
                else begin
                    mk = 8'h00;
                    for (int i = 0; i < 8; i++) if ((i + 1) * DW <= mt) mk[i] = 1'b1;
                    chk("sweep_busy", busy, 1);
                    chk("sweep_done", done, 0);
                    chk("sweep_abc", {a_out, b_out, c_out}, mt / DW);
                    chk("sweep_truth", truth, m_tt & mk);
                    chk("sweep_match", match, 0);
                end
            end
            if (mode == 2) begin
                chk("hold_done", done, 1);
                chk("hold_busy", busy, 0);
                chk("hold_abc", {a_out, b_out, c_out}, 0);
                chk("hold_truth", truth, m_tt);
                chk("hold_match", match, m_tt == EXP);
            end else if (mode == 0) begin
                chk("idle_outs", {a_out, b_out, c_out, busy, done, match, truth}, 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic sweep(input logic [7:0] tt);
        @(negedge clk);
        tbl   = tt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_tt  = tt;
        m_k   = ecount;
        mode  = 1;
        q.push_back('{tt, tt == EXP, ecount + 8 * DW});
    endtask

    task automatic extra_start(input int after);
        repeat (after) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (!done && i < 8 * DW + 4) begin
            @(negedge clk);
            i++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d clks", 8 * DW + 4);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {a_out, b_out, c_out, busy, done, match, truth}, 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            #1;
            chk_zero("reset_outs");
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        sweep(8'h45);
        wait_done();
        repeat (3) @(negedge clk);

        sweep(8'h65);
        wait_done();
        repeat (2) @(negedge clk);

        sweep(8'h45);
        extra_start(6);
        wait_done();

        sweep(8'h9c);
        wait_done();
        sweep(8'h45);
        wait_done();

        sweep(8'h45);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midsweep_reset");
        q.delete();
        mode = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sweep(8'h45);
        wait_done();

        for (int r = 0; r < 12; r++) begin
            logic [7:0] tt;
            tt = ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom);
            sweep(tt);
            if ($urandom_range(0, 1) == 1) extra_start($urandom_range(1, 8 * DW - 3));
            wait_done();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
